// File: rtl/shift_add_mult_ctrl.sv
// Unsigned N x N shift-and-add multiplier on one N-bit ripple adder; N+2 cycles per product.
// Operands accepted only in IDLE; the product is held in DONE until out_ready.
module shift_add_mult_ctrl #(
  parameter int N = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  m_q, m_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  addend;
  logic [N-1:0]  sum;
  logic [N:0]    carry;

  // Ripple full adder, cin tied low; addend is M gated by the multiplier LSB
  always_comb begin
    addend   = q_q[0] ? m_q : '0;
    sum      = '0;
    carry    = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum[i]     = a_q[i] ^ addend[i] ^ carry[i];
      carry[i+1] = (a_q[i] & addend[i]) | (carry[i] & (a_q[i] ^ addend[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = a;
          q_d     = b;
          a_d     = '0;
          cnt_d   = CW'(N);
          state_d = RUN;
        end
      end
      RUN: begin
        // Shift the (2N+1)-bit {carry, sum, Q} right by one
        a_d   = {carry[N], sum[N-1:1]};
        q_d   = {sum[0], q_q[N-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign p         = {a_q, q_q};

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl (N=10): directed scenarios then random back-to-back traffic.
module tb_shift_add_mult_ctrl;

  localparam int N = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*N-1:0] sb_q[$];
  int n_sent = 0;
  int n_recv = 0;

  shift_add_mult_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand pair through the handshake and record the expected product
  task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, output bit ok);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    ok = in_ready;
    step();
    in_valid = 1'b0;
    if (ok) begin
      sb_q.push_back((2*N)'(av) * (2*N)'(bv));
      n_sent++;
    end
  endtask

  // Count cycles until out_valid (-1 on timeout) and how many of them had busy high
  task automatic wait_out(output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = 0;
    while (!out_valid && cyc < 100) begin
      if (busy) bcyc++;
      step();
      cyc++;
    end
    if (!out_valid) cyc = -1;
  endtask

  task automatic take(output logic [2*N-1:0] got);
    out_ready = 1'b1;
    got       = p;
    step();
    out_ready = 1'b0;
    n_recv++;
  endtask

  function automatic logic [2*N-1:0] pop_exp();
    if (sb_q.size() == 0) return '1;
    return sb_q.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    step();
    step();
    n_checks++;
    if ({in_ready, out_valid, busy, p} !== {1'b1, 1'b0, 1'b0, {(2*N){1'b0}}})
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b p=%0d, want rdy=1 vld=0 busy=0 p=0",
               in_ready, out_valid, busy, p);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_latency();
    bit ok; int cyc, bcyc; logic [2*N-1:0] got, exp;
    send(3, 5, ok);
    wait_out(cyc, bcyc);
    n_checks++;
    if (cyc !== 10) $display("FAIL latency_3x5: out_valid after %0d cycles, want 10", cyc);
    else n_pass++;
    exp = pop_exp();
    take(got);
    n_checks++;
    if (got !== exp || !ok) $display("FAIL product_3x5: got %0d, want %0d", got, exp);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL drain_3x5: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_max();
    bit ok; int cyc, bcyc; logic [2*N-1:0] got, exp;
    send(1023, 1023, ok);
    wait_out(cyc, bcyc);
    exp = pop_exp();
    take(got);
    n_checks++;
    if (got !== 20'hFF801 || exp !== 20'hFF801 || cyc < 0)
      $display("FAIL product_max: got %0h, want ff801", got);
    else n_pass++;
  endtask

  task automatic test_zero_pow();
    bit ok; int cyc, bcyc; logic [2*N-1:0] got, exp;
    logic [N-1:0] av[2];
    logic [N-1:0] bv[2];
    av[0] = 0;   bv[0] = 777;
    av[1] = 512; bv[1] = 512;
    for (int i = 0; i < 2; i++) begin
      send(av[i], bv[i], ok);
      // send returns one cycle into RUN; that cycle is busy too
      wait_out(cyc, bcyc);
      exp = pop_exp();
      take(got);
      n_checks++;
      if (got !== exp || cyc < 0) $display("FAIL product_%0dx%0d: got %0d, want %0d", av[i], bv[i], got, exp);
      else n_pass++;
      n_checks++;
      if (bcyc !== 10) $display("FAIL busy_len_%0d: busy for %0d cycles, want 10", i, bcyc);
      else n_pass++;
    end
    n_checks++;
    if (got !== 20'd262144) $display("FAIL product_pow2: got %0d, want 262144", got);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit ok; int cyc, bcyc; logic [2*N-1:0] got, exp;
    send(100, 7, ok);
    in_valid = 1'b1; a = 11; b = 13;
    wait_out(cyc, bcyc);
    exp = pop_exp();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      step();
      n_checks++;
      if (out_valid !== 1'b1 || p !== 20'd700 || in_ready !== 1'b0)
        $display("FAIL stall_hold_%0d: vld=%b p=%0d rdy=%b, want vld=1 p=700 rdy=0", i, out_valid, p, in_ready);
      else n_pass++;
    end
    in_valid = 1'b0;
    take(got);
    n_checks++;
    if (got !== exp || cyc < 0) $display("FAIL product_stall: got %0d, want %0d", got, exp);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL no_second_accept: rdy=%b vld=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit ok; int cyc, bcyc; logic [2*N-1:0] got, exp;
    send(100, 3, ok);
    void'(sb_q.pop_back());
    n_sent--;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy, p} !== {1'b1, 1'b0, 1'b0, {(2*N){1'b0}}})
      $display("FAIL mid_reset: rdy=%b vld=%b busy=%b p=%0d, want 1 0 0 0", in_ready, out_valid, busy, p);
    else n_pass++;
    send(9, 9, ok);
    wait_out(cyc, bcyc);
    exp = pop_exp();
    take(got);
    n_checks++;
    if (got !== 20'd81 || exp !== 20'd81 || cyc < 0) $display("FAIL product_after_reset: got %0d, want 81", got);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc, bcyc, stall, errs; logic [2*N-1:0] got, exp;
    logic [N-1:0] av, bv;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      av = N'($urandom_range(0, 1023));
      bv = N'($urandom_range(0, 1023));
      send(av, bv, ok);
      wait_out(cyc, bcyc);
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) step();
      exp = pop_exp();
      take(got);
      n_checks++;
      if (got !== exp || cyc < 0 || !ok) begin
        if (errs < 10) $display("FAIL rand_%0d %0dx%0d: got %0d, want %0d", i, av, bv, got, exp);
        errs++;
      end else n_pass++;
    end
    n_checks++;
    if (sb_q.size() != 0 || n_sent != n_recv || out_valid !== 1'b0)
      $display("FAIL rand_accounting: sent=%0d recv=%0d left=%0d vld=%b, want equal, 0 left, vld=0",
               n_sent, n_recv, sb_q.size(), out_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_max();
    test_zero_pow();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
